// File: rtl/oled_pkg.sv
// Shared constants, opcodes and decoder state type for the OLED SPI command/data decoder.
package oled_pkg;

   localparam int NUM_PAGES = 4;
   localparam int NUM_COLS  = 128;
   localparam int PAGE_W    = $clog2(NUM_PAGES);
   localparam int COL_W     = $clog2(NUM_COLS);

   localparam logic [7:0] OP_DISPLAY_OFF = 8'hAE;
   localparam logic [7:0] OP_DISPLAY_ON  = 8'hAF;
   localparam logic [7:0] OP_ENTIRE_OFF  = 8'hA4;
   localparam logic [7:0] OP_ENTIRE_ON   = 8'hA5;
   localparam logic [7:0] OP_CONTRAST    = 8'h81;
   localparam logic [7:0] OP_CHARGE_PUMP = 8'h8D;
   localparam logic [7:0] OP_PRECHARGE   = 8'hD9;
   localparam logic [7:0] OP_COM_CFG     = 8'hDA;
   localparam logic [7:0] OP_PAGE_ADDR   = 8'h22;

   localparam logic [7:0] CONTRAST_RST  = 8'h7F;
   localparam logic [7:0] PRECHARGE_RST = 8'h22;
   localparam logic [7:0] COM_CFG_RST   = 8'h12;

   typedef enum logic [0:0] {
      CMD_IDLE = 1'b0,
      CMD_ARG  = 1'b1
   } cmd_state_t;

   // Opcodes that take one argument byte before they take effect
   function automatic logic is_arg_opcode(input logic [7:0] op);
      return (op == OP_CONTRAST) || (op == OP_CHARGE_PUMP) || (op == OP_PRECHARGE) ||
             (op == OP_COM_CFG)  || (op == OP_PAGE_ADDR);
   endfunction

endpackage

// File: rtl/oled_spi_decoder_if.sv
// Byte bus from the SPI receiver to the decoder, and the display-RAM pixel write bus.
interface spi_byte_if;
   logic       byteValid;
   logic [7:0] byteData;
   logic       dc;

   modport master (output byteValid, output byteData, output dc);
   modport slave  (input  byteValid, input  byteData, input  dc);
endinterface

interface oled_spi_decoder_if;
   logic       valid;
   logic [8:0] addr;
   logic [7:0] data;

   modport master (output valid, output addr, output data);
   modport slave  (input  valid, input  addr, input  data);
endinterface

// File: rtl/oled_spi_decoder_rx.sv
// SPI byte receiver: input synchronizers, SCLK/SS edge detect, MSB-first shifter, framing error.
module spi_byte_rx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       ss,
   input  logic       mosi,
   input  logic       dc,
   spi_byte_if.master byte_bus,
   output logic       frame_err
);

   logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync, dc_sync;
   logic                   sclk_d, ss_d;
   logic [2:0]             bit_cnt;
   logic [6:0]             shreg;
   logic                   sclk_s, ss_s, mosi_s, dc_s;
   logic                   sample, ss_rise, last_bit;

   assign sclk_s = sclk_sync[SYNC_STAGES-1];
   assign ss_s   = ss_sync[SYNC_STAGES-1];
   assign mosi_s = mosi_sync[SYNC_STAGES-1];
   assign dc_s   = dc_sync[SYNC_STAGES-1];

   // The frame is still open in the cycle SS is seen rising, so a final edge there still counts
   assign ss_rise  = ss_s & ~ss_d;
   assign sample   = sclk_s & ~sclk_d & ~(ss_s & ss_d);
   assign last_bit = sample & (bit_cnt == 3'd7);

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync          <= '1;
         ss_sync            <= '1;
         mosi_sync          <= '0;
         dc_sync            <= '0;
         sclk_d             <= 1'b1;
         ss_d               <= 1'b1;
         bit_cnt            <= 3'd0;
         byte_bus.byteValid <= 1'b0;
         frame_err          <= 1'b0;
      end else begin
         sclk_sync          <= {sclk_sync[SYNC_STAGES-2:0], sclk};
         ss_sync            <= {ss_sync[SYNC_STAGES-2:0], ss};
         mosi_sync          <= {mosi_sync[SYNC_STAGES-2:0], mosi};
         dc_sync            <= {dc_sync[SYNC_STAGES-2:0], dc};
         sclk_d             <= sclk_s;
         ss_d               <= ss_s;
         byte_bus.byteValid <= last_bit;
         frame_err          <= ss_rise & ~last_bit & (bit_cnt != 3'd0);
         if (ss_rise)
            bit_cnt <= 3'd0;
         else if (sample)
            bit_cnt <= bit_cnt + 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (sample)
         shreg <= {shreg[5:0], mosi_s};
      if (last_bit) begin
         byte_bus.byteData <= {shreg, mosi_s};
         byte_bus.dc       <= dc_s;
      end
   end

endmodule

// File: rtl/oled_spi_decoder.sv
// OLED SPI command/data decoder top. Optional framing-error counter output under OLED_DEC_ERR_CNT_EN.
module oled_spi_decoder
   import oled_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic              sysClkIn,
   input  logic              sysRstIn,
   input  logic              SCLK,
   input  logic              SS,
   input  logic              MOSI,
   input  logic              DC,
   output logic              pixWriteValidOut,
   output logic [8:0]        pixWriteAddrOut,
   output logic [7:0]        pixWriteDataOut,
   output logic              displayOnOut,
   output logic              entireOnOut,
   output logic              chargePumpOnOut,
   output logic [7:0]        contrastOut,
   output logic [7:0]        preChargeOut,
   output logic [7:0]        comCfgOut,
   output logic [PAGE_W-1:0] pageOut,
   output logic [COL_W-1:0]  colOut,
   output logic              errorOut
`ifdef OLED_DEC_ERR_CNT_EN
   ,
   output logic [7:0]        errCntOut
`endif
);

   spi_byte_if rx_bus ();
   logic       frame_err;
   cmd_state_t state;
   logic [7:0] opcode;
   logic [7:0] rx_byte;

   spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_rx (
      .clk       (sysClkIn),
      .rst       (sysRstIn),
      .sclk      (SCLK),
      .ss        (SS),
      .mosi      (MOSI),
      .dc        (DC),
      .byte_bus  (rx_bus.master),
      .frame_err (frame_err)
   );

   assign rx_byte = rx_bus.byteData;

   always_ff @(posedge sysClkIn) begin
      if (sysRstIn) begin
         pixWriteValidOut <= 1'b0;
         pixWriteAddrOut  <= '0;
         pixWriteDataOut  <= '0;
         displayOnOut     <= 1'b0;
         entireOnOut      <= 1'b0;
         chargePumpOnOut  <= 1'b0;
         contrastOut      <= CONTRAST_RST;
         preChargeOut     <= PRECHARGE_RST;
         comCfgOut        <= COM_CFG_RST;
         pageOut          <= '0;
         colOut           <= '0;
         errorOut         <= 1'b0;
         state            <= CMD_IDLE;
         opcode           <= '0;
`ifdef OLED_DEC_ERR_CNT_EN
         errCntOut        <= '0;
`endif
      end else begin
         pixWriteValidOut <= 1'b0;
         if (frame_err) begin
            errorOut <= 1'b1;
`ifdef OLED_DEC_ERR_CNT_EN
            if (errCntOut != 8'hFF)
               errCntOut <= errCntOut + 8'd1;
`endif
         end

         if (rx_bus.byteValid) begin
            if (rx_bus.dc) begin
               // A data byte also cancels any command still waiting for its argument
               state            <= CMD_IDLE;
               pixWriteValidOut <= 1'b1;
               pixWriteAddrOut  <= {pageOut, colOut};
               pixWriteDataOut  <= rx_byte;
               if (colOut == COL_W'(NUM_COLS - 1)) begin
                  colOut  <= '0;
                  pageOut <= pageOut + PAGE_W'(1);
               end else begin
                  colOut <= colOut + COL_W'(1);
               end
            end else if (state == CMD_ARG) begin
               state <= CMD_IDLE;
               case (opcode)
                  OP_CONTRAST:    contrastOut     <= rx_byte;
                  OP_CHARGE_PUMP: chargePumpOnOut <= rx_byte[2];
                  OP_PRECHARGE:   preChargeOut    <= rx_byte;
                  OP_COM_CFG:     comCfgOut       <= rx_byte;
                  OP_PAGE_ADDR:   pageOut         <= rx_byte[PAGE_W-1:0];
                  default:        ;
               endcase
            end else begin
               case (rx_byte)
                  OP_DISPLAY_OFF: displayOnOut <= 1'b0;
                  OP_DISPLAY_ON:  displayOnOut <= 1'b1;
                  OP_ENTIRE_OFF:  entireOnOut  <= 1'b0;
                  OP_ENTIRE_ON:   entireOnOut  <= 1'b1;
                  default: begin
                     if (is_arg_opcode(rx_byte)) begin
                        opcode <= rx_byte;
                        state  <= CMD_ARG;
                     end else if (rx_byte[7:4] == 4'h0) begin
                        colOut <= {colOut[6:4], rx_byte[3:0]};
                     end else if (rx_byte[7:3] == 5'b00010) begin
                        colOut <= {rx_byte[2:0], colOut[3:0]};
                     end
                  end
               endcase
            end
         end
      end
   end

endmodule
